// File: rtl/midi_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : midi_uart_rx
//  Purpose  : MIDI serial receiver (31250 baud, 8N1). Oversamples the rx
//             line on a clock-enable tick (OVERSAMPLE ticks per bit),
//             samples each bit at its middle and emits the received byte
//             with a one-cycle valid strobe. A low stop bit produces a
//             one-cycle frame_err strobe instead.
//  Ports    : clk       - system clock, rising edge
//             rst_n     - asynchronous active-low reset
//             tick      - oversampling enable, one clk wide
//             rx        - asynchronous serial input, idle high
//             data[7:0] - last correctly framed byte (LSB first on line)
//             valid     - one-clk strobe, data new on the same cycle
//             frame_err - one-clk strobe when the stop bit samples low
//             busy      - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module midi_uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int CW         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CW-1:0] c_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] c_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t         r_state, w_state_nxt;
  logic           r_rx_meta, r_rx_s;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [2:0]     r_bit, w_bit_nxt;
  logic [7:0]     r_shift, w_shift_nxt;
  logic [7:0]     r_data, w_data_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_ferr, w_ferr_nxt;

  // Two-flop synchroniser; reset to the idle (high) line level so a reset
  // release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (tick && !r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      S_START: begin
        if (tick) begin
          if (r_cnt == c_HALF) begin
            w_cnt_nxt = '0;
            if (!r_rx_s) begin
              // Still low at mid start bit: a genuine start. From here on
              // every sample is a full bit period later, i.e. mid-bit.
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (r_cnt == c_LAST) begin
            // LSB arrives first, so shift right and insert at the MSB.
            w_shift_nxt = {r_rx_s, r_shift[7:1]};
            w_cnt_nxt   = '0;
            if (r_bit == 3'd7) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (r_cnt == c_LAST) begin
            w_cnt_nxt = '0;
            if (r_rx_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      S_WAIT_HIGH: begin
        // Not tick-gated: leave as soon as the line is released so a held
        // break is never mistaken for a new start bit.
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_midi_uart_rx
//  Purpose  : Self-checking bench for midi_uart_rx. Frames are driven bit by
//             bit; each expected outcome (byte or framing error) is queued
//             when the frame is sent and compared when the DUT strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_midi_uart_rx;

  localparam int c_OS        = 16;
  localparam int c_TICK_DIV  = 4;
  localparam int c_BIT_CLK   = c_OS * c_TICK_DIV;

  typedef struct packed {
    logic       err;
    logic [7:0] d;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  logic       tick_en;
  int         tcnt;
  int         n_checks;
  int         n_errors;
  exp_t       sb[$];
  logic [7:0] last_good;

  midi_uart_rx #(
    .OVERSAMPLE(c_OS),
    .CW        (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick generator: one clk-wide pulse every c_TICK_DIV clocks, changed on
  // the falling edge so it is stable at the DUT's rising edge.
  initial begin
    tick = 1'b0;
    tcnt = 0;
  end
  always @(negedge clk) begin
    if (!tick_en) begin
      tick = 1'b0;
    end else begin
      tcnt = (tcnt + 1) % c_TICK_DIV;
      tick = (tcnt == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      check_eq("strobe_exclusive", {15'd0, valid & frame_err}, 16'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_strobe", 16'(sb.size()), 16'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("strobe_kind", {15'd0, frame_err}, {15'd0, e.err});
        check_eq("strobe_data", {8'd0, data}, {8'd0, e.d});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one bit period; optionally freeze ticks for 200 clk mid-bit.
  task automatic send_bit(input logic v, input bit pause);
    rx = v;
    if (pause) begin
      wait_clk(c_BIT_CLK / 2);
      tick_en = 1'b0;
      wait_clk(200);
      tick_en = 1'b1;
      wait_clk(c_BIT_CLK - c_BIT_CLK / 2);
    end else begin
      wait_clk(c_BIT_CLK);
    end
  endtask

  // Full frame. pause_bit selects which line bit (0=start..9=stop) gets
  // the tick freeze; -1 for none.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int pause_bit);
    exp_t e;
    if (stop_v) begin
      e.err     = 1'b0;
      e.d       = b;
      last_good = b;
    end else begin
      e.err = 1'b1;
      e.d   = last_good;
    end
    sb.push_back(e);
    send_bit(1'b0, pause_bit == 0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i], pause_bit == i + 1);
      if (i == 3) check_eq("busy_mid_frame", {15'd0, busy}, 16'd1);
    end
    send_bit(stop_v, pause_bit == 9);
  endtask

  task automatic expect_drained(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) wait_clk(1);
    check_eq(tag, 16'(sb.size()), 16'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    last_good = 8'h00;
    tick_en   = 1'b1;
    rx        = 1'b1;
    rst_n     = 1'b0;
    wait_clk(5);
    check_eq("rst_data", {8'd0, data}, 16'd0);
    check_eq("rst_valid", {15'd0, valid}, 16'd0);
    check_eq("rst_ferr", {15'd0, frame_err}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    wait_clk(20);

    // Single byte
    send_byte(8'h90, 1'b1, -1);
    expect_drained("drain_90");
    wait_clk(16);
    check_eq("idle_after_90", {15'd0, busy}, 16'd0);

    // Back-to-back, no idle gap
    send_byte(8'h55, 1'b1, -1);
    send_byte(8'hAA, 1'b1, -1);
    expect_drained("drain_55_aa");
    wait_clk(64);

    // Start glitch of 3 ticks
    rx = 1'b0;
    wait_clk(3 * c_TICK_DIV);
    rx = 1'b1;
    wait_clk(2 * c_BIT_CLK);
    check_eq("glitch_idle", {15'd0, busy}, 16'd0);
    check_eq("glitch_no_strobe", 16'(sb.size()), 16'd0);

    // Framing error followed by a 40-bit break
    send_byte(8'h3C, 1'b0, -1);
    rx = 1'b0;
    wait_clk(40 * c_BIT_CLK);
    expect_drained("drain_ferr");
    check_eq("break_busy", {15'd0, busy}, 16'd1);
    check_eq("break_data_kept", {8'd0, data}, {8'd0, last_good});
    rx = 1'b1;
    wait_clk(c_BIT_CLK);
    check_eq("break_released", {15'd0, busy}, 16'd0);
    send_byte(8'h81, 1'b1, -1);
    expect_drained("drain_81");
    wait_clk(32);

    // Reset during bit 4 of 0xF0
    rx = 1'b0;
    wait_clk(c_BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = (i >= 4);
      wait_clk(c_BIT_CLK);
    end
    rx = 1'b1;
    wait_clk(c_BIT_CLK / 2);
    rst_n = 1'b0;
    wait_clk(3);
    check_eq("midrst_data", {8'd0, data}, 16'd0);
    check_eq("midrst_valid", {15'd0, valid}, 16'd0);
    check_eq("midrst_ferr", {15'd0, frame_err}, 16'd0);
    check_eq("midrst_busy", {15'd0, busy}, 16'd0);
    last_good = 8'h00;
    wait_clk(c_BIT_CLK);
    rst_n = 1'b1;
    wait_clk(6 * c_BIT_CLK);
    check_eq("postrst_no_strobe", 16'(sb.size()), 16'd0);
    send_byte(8'h12, 1'b1, -1);
    expect_drained("drain_12");
    wait_clk(32);

    // Tick freeze in the middle of data bit 5
    send_byte(8'hA7, 1'b1, 6);
    expect_drained("drain_pause");
    wait_clk(32);
    check_eq("final_data", {8'd0, data}, 16'h00A7);
    check_eq("final_idle", {15'd0, busy}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
